// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// halt-cause codes and the default reset PC.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_STOP     = 2'd1,
        CAUSE_BREAK    = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } halt_cause_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Word-address compare; byte-offset bits are masked rather than sliced away.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & ~32'h0000_0003) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, commits npc
// on exec_done, and provides run/halt, single-step and one breakpoint.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic [9:0]  pc_idx,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    seq_state_t  state;
    halt_cause_t cause_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic        req_q;
    logic        valid_q;
    logic        halted_q;
    logic        step_once;

    // Moore outputs are kept as registers updated alongside every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HALT;
            cause_q   <= CAUSE_STOP;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b1;
            step_once <= 1'b0;
        end else begin
            case (state)
                ST_HALT: begin
                    // A misaligned-npc halt is sticky: only reset leaves it.
                    if (cause_q != CAUSE_MISALIGN && (run || step)) begin
                        state     <= ST_FETCH;
                        req_q     <= 1'b1;
                        halted_q  <= 1'b0;
                        cause_q   <= CAUSE_NONE;
                        step_once <= step && !run;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state   <= ST_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        valid_q <= 1'b0;
                        if (npc[1:0] != 2'b00) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                            cause_q  <= CAUSE_MISALIGN;
                        end else begin
                            pc_q      <= npc;
                            retired_q <= retired_q + 32'd1;
                            if (step_once) begin
                                step_once <= 1'b0;
                                state     <= ST_HALT;
                                halted_q  <= 1'b1;
                                cause_q   <= CAUSE_STOP;
                            end else if (!run) begin
                                state    <= ST_HALT;
                                halted_q <= 1'b1;
                                cause_q  <= CAUSE_STOP;
                            end else if (bp_en && word_match(npc, bp_addr)) begin
                                state    <= ST_HALT;
                                halted_q <= 1'b1;
                                cause_q  <= CAUSE_BREAK;
                            end else begin
                                state <= ST_FETCH;
                                req_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_HALT;
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                    cause_q  <= CAUSE_STOP;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_idx      = pc_q[11:2];
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences
// and randomized stimulus against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step, bp_en, imem_ack, exec_done;
    logic [31:0] bp_addr, imem_rdata, npc;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc, retired;
    logic [9:0]  pc_idx;
    logic [1:0]  halt_cause;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .bp_en(bp_en),
        .bp_addr(bp_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .npc(npc), .pc(pc),
        .pc_idx(pc_idx), .halted(halted), .halt_cause(halt_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic e_req, input logic e_vld,
                         input logic e_hlt, input logic [1:0] e_cause,
                         input logic [31:0] e_pc, input logic [31:0] e_ret,
                         input logic [31:0] e_instr);
        logic [9:0] e_idx;
        e_idx = e_pc[11:2];
        checks++;
        if (imem_req !== e_req || instr_valid !== e_vld || halted !== e_hlt ||
            halt_cause !== e_cause || pc !== e_pc || imem_addr !== e_pc ||
            pc_idx !== e_idx || retired !== e_ret || instr !== e_instr) begin
            errors++;
            $display("FAIL %s: got req=%0b vld=%0b hlt=%0b cause=%0d pc=%h addr=%h idx=%h ret=%0d instr=%h ; required req=%0b vld=%0b hlt=%0b cause=%0d pc=%h idx=%h ret=%0d instr=%h",
                     name, imem_req, instr_valid, halted, halt_cause, pc, imem_addr, pc_idx,
                     retired, instr, e_req, e_vld, e_hlt, e_cause, e_pc, e_idx, e_ret, e_instr);
        end
    endtask

    // Directed vector table
    typedef struct {
        logic        run, step, ack, done;
        logic [31:0] npc;
        logic        bp_en;
        logic [31:0] bp_addr;
        logic        req, vld, hlt;
        logic [1:0]  cause;
        logic [31:0] pc, ret;
        int          iidx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic a, logic d, logic [31:0] n,
                                logic be, logic [31:0] ba, logic q, logic v, logic h,
                                logic [1:0] c, logic [31:0] p, logic [31:0] rt, int ii);
        vec_t t;
        t.run = r; t.step = s; t.ack = a; t.done = d; t.npc = n; t.bp_en = be;
        t.bp_addr = ba; t.req = q; t.vld = v; t.hlt = h; t.cause = c; t.pc = p;
        t.ret = rt; t.iidx = ii;
        return t;
    endfunction

    function automatic logic [31:0] rdata_of(int i);
        return 32'h0BAD_0000 + i;
    endfunction

    // Behavioural model of the sequencer
    logic [31:0] m_pc, m_ret, m_instr;
    logic [1:0]  m_cause;
    logic        m_halted, m_fetching, m_executing, m_step_once;

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_ret = 0; m_instr = 0; m_cause = 2'd1;
        m_halted = 1; m_fetching = 0; m_executing = 0; m_step_once = 0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic a,
                              input logic [31:0] rd, input logic d,
                              input logic [31:0] n, input logic be, input logic [31:0] ba);
        if (m_halted) begin
            if (m_cause != 2'd3 && (r || s)) begin
                m_halted = 0; m_fetching = 1; m_cause = 2'd0; m_step_once = s && !r;
            end
        end else if (m_fetching) begin
            if (a) begin
                m_instr = rd; m_fetching = 0; m_executing = 1;
            end
        end else if (m_executing && d) begin
            m_executing = 0;
            if (n[1:0] != 2'b00) begin
                m_halted = 1; m_cause = 2'd3;
            end else begin
                m_pc = n;
                m_ret = m_ret + 1;
                if (m_step_once) begin
                    m_step_once = 0; m_halted = 1; m_cause = 2'd1;
                end else if (!r) begin
                    m_halted = 1; m_cause = 2'd1;
                end else if (be && n[31:2] == ba[31:2]) begin
                    m_halted = 1; m_cause = 2'd2;
                end else begin
                    m_fetching = 1;
                end
            end
        end
    endtask

    initial begin
        run = 0; step = 0; bp_en = 0; bp_addr = 0; imem_ack = 0; imem_rdata = 0;
        exec_done = 0; npc = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("reset_state", 0, 0, 1, 2'd1, 32'h3000, 0, 0);
        rst_n = 1;
        @(negedge clk);
        check("after_release", 0, 0, 1, 2'd1, 32'h3000, 0, 0);

        //              run s ack dn npc          be bp_addr       req vld hlt cause pc   ret iidx
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       0, 32'h0,        1, 0, 0, 2'd0, 32'h3000, 0, -1));
        tbl.push_back(mk(1, 0, 1, 1, 32'h3004,    0, 32'h0,        0, 1, 0, 2'd0, 32'h3000, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 32'h3004,    0, 32'h0,        1, 0, 0, 2'd0, 32'h3004, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       0, 32'h0,        0, 1, 0, 2'd0, 32'h3004, 1, 3));
        tbl.push_back(mk(1, 0, 0, 1, 32'h3008,    0, 32'h0,        1, 0, 0, 2'd0, 32'h3008, 2, 3));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       0, 32'h0,        0, 1, 0, 2'd0, 32'h3008, 2, 5));
        tbl.push_back(mk(1, 0, 0, 1, 32'h300C,    0, 32'h0,        1, 0, 0, 2'd0, 32'h300C, 3, 5));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       1, 32'h3012,     0, 1, 0, 2'd0, 32'h300C, 3, 7));
        tbl.push_back(mk(1, 0, 0, 1, 32'h3010,    1, 32'h3012,     0, 0, 1, 2'd2, 32'h3010, 4, 7));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h3012,     0, 0, 1, 2'd2, 32'h3010, 4, 7));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,       1, 32'h3012,     1, 0, 0, 2'd0, 32'h3010, 4, 7));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       1, 32'h3012,     0, 1, 0, 2'd0, 32'h3010, 4, 11));
        tbl.push_back(mk(1, 0, 0, 1, 32'h3014,    1, 32'h3012,     1, 0, 0, 2'd0, 32'h3014, 5, 11));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 32'h0,        0, 1, 0, 2'd0, 32'h3014, 5, 13));
        tbl.push_back(mk(0, 0, 0, 1, 32'h3018,    0, 32'h0,        0, 0, 1, 2'd1, 32'h3018, 6, 13));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        1, 0, 0, 2'd0, 32'h3018, 6, 13));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        1, 0, 0, 2'd0, 32'h3018, 6, 13));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 32'h0,        0, 1, 0, 2'd0, 32'h3018, 6, 17));
        tbl.push_back(mk(0, 0, 0, 1, 32'h301C,    0, 32'h0,        0, 0, 1, 2'd1, 32'h301C, 7, 17));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 1, 2'd1, 32'h301C, 7, 17));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,       0, 32'h0,        1, 0, 0, 2'd0, 32'h301C, 7, 17));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,       0, 32'h0,        0, 1, 0, 2'd0, 32'h301C, 7, 21));
        tbl.push_back(mk(1, 0, 0, 1, 32'h3022,    0, 32'h0,        0, 0, 1, 2'd3, 32'h301C, 7, 21));
        tbl.push_back(mk(1, 1, 1, 1, 32'h3020,    0, 32'h0,        0, 0, 1, 2'd3, 32'h301C, 7, 21));

        for (int i = 0; i < tbl.size(); i++) begin
            run = tbl[i].run; step = tbl[i].step; imem_ack = tbl[i].ack;
            imem_rdata = rdata_of(i); exec_done = tbl[i].done; npc = tbl[i].npc;
            bp_en = tbl[i].bp_en; bp_addr = tbl[i].bp_addr;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].req, tbl[i].vld, tbl[i].hlt, tbl[i].cause,
                  tbl[i].pc, tbl[i].ret, (tbl[i].iidx < 0) ? 32'h0 : rdata_of(tbl[i].iidx));
        end

        // Reset clears the sticky misalign halt; an ack held across reset is ignored.
        run = 0; step = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; exec_done = 0;
        bp_en = 0;
        rst_n = 0;
        #1;
        check("rst_restore", 0, 0, 1, 2'd1, 32'h3000, 0, 0);
        rst_n = 1;
        @(negedge clk);
        check("ack_after_rst", 0, 0, 1, 2'd1, 32'h3000, 0, 0);

        // Three-cycle ack delay: request and address held for four cycles.
        run = 1; imem_ack = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wait_req%0d", k), 1, 0, 0, 2'd0, 32'h3000, 0, 0);
            if (k == 3) begin
                imem_ack = 1; imem_rdata = 32'hFEED_0001;
            end
            @(negedge clk);
        end
        imem_ack = 0;
        check("wait_latch", 0, 1, 0, 2'd0, 32'h3000, 0, 32'hFEED_0001);

        // Asynchronous reset mid-EXEC takes effect without a clock edge.
        #2;
        rst_n = 0;
        #1;
        check("async_rst", 0, 0, 1, 2'd1, 32'h3000, 0, 0);
        @(negedge clk);
        rst_n = 1;
        run = 0;

        // Randomized phase against the behavioural model
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            logic        r_run, r_step, r_ack, r_done, r_be;
            logic [31:0] r_rd, r_npc, r_ba;
            int          sel;
            @(negedge clk);
            check("rand", m_fetching, m_executing, m_halted, m_cause, m_pc, m_ret, m_instr);
            if ($urandom_range(0, 299) == 0 || (m_cause == 2'd3 && $urandom_range(0, 9) == 0)) begin
                rst_n = 0;
                #1;
                model_reset();
                check("rand_rst", m_fetching, m_executing, m_halted, m_cause, m_pc, m_ret, m_instr);
                rst_n = 1;
            end
            r_run  = ($urandom_range(0, 9) != 0);
            r_step = ($urandom_range(0, 7) == 0);
            r_ack  = ($urandom_range(0, 1) == 0);
            r_done = ($urandom_range(0, 1) == 0);
            r_rd   = $urandom;
            sel    = $urandom_range(0, 99);
            if (sel < 88)
                r_npc = m_pc + 32'd4;
            else if (sel < 97)
                r_npc = 32'h3000 + ($urandom_range(0, 255) << 2);
            else
                r_npc = m_pc + $urandom_range(1, 3);
            r_be = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 0)
                r_ba = (m_pc + 32'd4) | $urandom_range(0, 3);
            else
                r_ba = $urandom;
            run = r_run; step = r_step; imem_ack = r_ack; imem_rdata = r_rd;
            exec_done = r_done; npc = r_npc; bp_en = r_be; bp_addr = r_ba;
            model_step(r_run, r_step, r_ack, r_rd, r_done, r_npc, r_be, r_ba);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
